wb_downsizer: RTL and testbench



---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_downsizer.sv | 189 ++++++++++++++++++
 tb/tb_wb_downsizer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the Wishbone downsizer: FSM state encoding and width-ratio helper.
package wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    GAP,
    RESP,
    HOLD
  } wb_dsz_state_t;

  function automatic int ratio_clog2(input int wide_width, input int narrow_width);
    return $clog2(wide_width / narrow_width);
  endfunction

endpackage

// File: rtl/wb_downsizer.sv
// Splits one wide Wishbone access into per-segment narrow accesses; response 1 cycle after last slave ack.
// Optional watchdog on slave responses via WB_DOWNSIZER_TIMEOUT_EN; otherwise ACCESS waits indefinitely.
module wb_downsizer
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int WBM_DATA_WIDTH   = 32,
  parameter int WBM_SELECT_WIDTH = WBM_DATA_WIDTH / 8,
  parameter int WBS_DATA_WIDTH   = 16,
  parameter int WBS_SELECT_WIDTH = WBS_DATA_WIDTH / 8,
  parameter int TIMEOUT          = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       wbm_adr_i,
  input  logic [WBM_DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [WBM_DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                        wbm_we_i,
  input  logic [WBM_SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                        wbm_stb_i,
  output logic                        wbm_ack_o,
  output logic                        wbm_err_o,
  output logic                        wbm_rty_o,
  input  logic                        wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]       wbs_adr_o,
  input  logic [WBS_DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [WBS_DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                        wbs_we_o,
  output logic [WBS_SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                        wbs_stb_o,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic                        wbs_cyc_o
);

  localparam int RATIO = WBM_DATA_WIDTH / WBS_DATA_WIDTH;
  localparam int SEG_W = (ratio_clog2(WBM_DATA_WIDTH, WBS_DATA_WIDTH) > 0) ?
                         ratio_clog2(WBM_DATA_WIDTH, WBS_DATA_WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(WBM_SELECT_WIDTH - 1));

  wb_dsz_state_t               state;
  logic [SEG_W-1:0]            seg;
  logic [ADDR_WIDTH-1:0]       adr_q;
  logic [WBM_DATA_WIDTH-1:0]   dat_q;
  logic [WBM_SELECT_WIDTH-1:0] sel_q;
  logic                        we_q;
  logic                        first_found, next_found;
  logic [SEG_W-1:0]            first_idx, next_idx;
  logic                        to_hit;

  function automatic logic [ADDR_WIDTH-1:0] seg_adr(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [SEG_W-1:0] k);
    return (a & ALIGN_MASK) + ADDR_WIDTH'(k) * ADDR_WIDTH'(WBS_SELECT_WIDTH);
  endfunction

  // Lowest non-empty segment of the incoming request, and of the latched one above seg.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (|wbm_sel_i[i*WBS_SELECT_WIDTH +: WBS_SELECT_WIDTH]) begin
        first_found = 1'b1;
        first_idx   = SEG_W'(i);
      end
      if (i > int'(seg) && |sel_q[i*WBS_SELECT_WIDTH +: WBS_SELECT_WIDTH]) begin
        next_found = 1'b1;
        next_idx   = SEG_W'(i);
      end
    end
  end

`ifdef WB_DOWNSIZER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`else
  // Watchdog absent: never fires for any legal TIMEOUT value.
  assign to_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      seg       <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_stb_o <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
`ifdef WB_DOWNSIZER_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            adr_q <= wbm_adr_i;
            dat_q <= wbm_dat_i;
            sel_q <= wbm_sel_i;
            we_q  <= wbm_we_i;
            seg   <= first_idx;
            if (first_found) begin
              state     <= ACCESS;
              wbs_cyc_o <= 1'b1;
              wbs_stb_o <= 1'b1;
              wbs_we_o  <= wbm_we_i;
              wbs_adr_o <= seg_adr(wbm_adr_i, first_idx);
              wbs_dat_o <= wbm_dat_i[first_idx*WBS_DATA_WIDTH +: WBS_DATA_WIDTH];
              wbs_sel_o <= wbm_sel_i[first_idx*WBS_SELECT_WIDTH +: WBS_SELECT_WIDTH];
`ifdef WB_DOWNSIZER_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end else begin
              state     <= RESP;
              wbm_ack_o <= 1'b1;
            end
          end
        end
        ACCESS: begin
`ifdef WB_DOWNSIZER_TIMEOUT_EN
          to_cnt <= to_cnt + 1'b1;
`endif
          if (!wbm_cyc_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            state     <= IDLE;
          end else if (wbs_err_i || wbs_rty_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbm_err_o <= wbs_err_i;
            wbm_rty_o <= !wbs_err_i;
            state     <= HOLD;
          end else if (wbs_ack_i) begin
            if (!we_q) wbm_dat_o[seg*WBS_DATA_WIDTH +: WBS_DATA_WIDTH] <= wbs_dat_i;
            wbs_stb_o <= 1'b0;
            if (next_found) begin
              seg   <= next_idx;
              state <= GAP;
            end else begin
              wbs_cyc_o <= 1'b0;
              wbm_ack_o <= 1'b1;
              state     <= RESP;
            end
          end else if (to_hit) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbm_err_o <= 1'b1;
            state     <= HOLD;
          end
        end
        GAP: begin
          if (!wbm_cyc_i) begin
            wbs_cyc_o <= 1'b0;
            state     <= IDLE;
          end else begin
            wbs_stb_o <= 1'b1;
            wbs_adr_o <= seg_adr(adr_q, seg);
            wbs_dat_o <= dat_q[seg*WBS_DATA_WIDTH +: WBS_DATA_WIDTH];
            wbs_sel_o <= sel_q[seg*WBS_SELECT_WIDTH +: WBS_SELECT_WIDTH];
            state     <= ACCESS;
`ifdef WB_DOWNSIZER_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        // HOLD swallows the stale stb of the request that was just answered.
        RESP:    state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_downsizer.sv
// Randomized bench for wb_downsizer (32->16) with a byte-memory slave and a transaction-level reference model.
module tb_wb_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic        wbm_we_i, wbm_stb_i, wbm_cyc_i;
  logic [3:0]  wbm_sel_i;
  logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs_adr_o;
  logic [15:0] wbs_dat_i, wbs_dat_o;
  logic        wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic [1:0]  wbs_sel_o;
  logic        wbs_ack_i, wbs_err_i, wbs_rty_i;

  always #5 clk = ~clk;

  wb_downsizer #(
    .ADDR_WIDTH(32), .WBM_DATA_WIDTH(32), .WBM_SELECT_WIDTH(4),
    .WBS_DATA_WIDTH(16), .WBS_SELECT_WIDTH(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbm_cyc_i(wbm_cyc_i),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .wbs_cyc_o(wbs_cyc_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
  } acc_t;

  // Slave modes: 0 normal ack, 1 err+rty+ack together, 2 silent, 3 rty+ack together.
  acc_t       log_q[$];
  acc_t       slv_acc;
  logic [7:0] slv_mem[256];
  logic [7:0] ref_mem[256];
  logic [7:0] slv_a;
  int         slv_mode = 0;
  int         slv_wait = 0;
  int         stb_cycles = 0;
  int         cyc_cycles = 0;
  logic [31:0] exp_rdat;

  always @(negedge clk) begin
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;
    if (wbs_cyc_o === 1'b1) cyc_cycles++;
    if (wbs_cyc_o === 1'b1 && wbs_stb_o === 1'b1) begin
      stb_cycles++;
      if (slv_mode != 2) begin
        if (slv_wait > 0) slv_wait--;
        else begin
          slv_acc.adr = wbs_adr_o;
          slv_acc.dat = wbs_dat_o;
          slv_acc.sel = wbs_sel_o;
          slv_acc.we  = wbs_we_o;
          log_q.push_back(slv_acc);
          slv_wait = $urandom_range(0, 2);
          if (slv_mode == 1) begin
            wbs_err_i = 1'b1; wbs_rty_i = 1'b1; wbs_ack_i = 1'b1;
          end else if (slv_mode == 3) begin
            wbs_rty_i = 1'b1; wbs_ack_i = 1'b1;
          end else begin
            wbs_ack_i = 1'b1;
            slv_a = wbs_adr_o[7:0];
            if (wbs_we_o) begin
              if (wbs_sel_o[0]) slv_mem[slv_a]      = wbs_dat_o[7:0];
              if (wbs_sel_o[1]) slv_mem[slv_a + 1'b1] = wbs_dat_o[15:8];
            end else begin
              wbs_dat_i = {slv_mem[slv_a + 1'b1], slv_mem[slv_a]};
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    log_q.delete();
    stb_cycles = 0;
    cyc_cycles = 0;
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel; wbm_we_i = we;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
  endtask

  task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic we,
                      output logic [2:0] resp, output logic [31:0] rdat);
    int budget;
    start(adr, dat, sel, we);
    resp = '0;
    rdat = '0;
    budget = 0;
    while (resp == 3'b000 && budget < 200) begin
      tick();
      budget++;
      resp = {wbm_rty_o, wbm_err_o, wbm_ack_o};
      rdat = wbm_dat_o;
    end
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    check({tag, ":responded"}, 64'(resp != 3'b000), 64'd1);
    tick();
    check({tag, ":pulse1"}, {wbm_rty_o, wbm_err_o, wbm_ack_o}, 3'b000);
  endtask

  // Reference: spec-level decomposition into narrow accesses plus byte-memory effect.
  task automatic run(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic we, output logic [31:0] rdat);
    acc_t        exp_q[$];
    acc_t        e;
    logic [31:0] base, nr;
    logic [2:0]  resp;
    base = adr & 32'hFFFF_FFFC;
    nr = exp_rdat;
    for (int k = 0; k < 2; k++) begin
      if (sel[2*k +: 2] != 2'b00) begin
        e.adr = base + 32'(2 * k);
        e.dat = dat[16*k +: 16];
        e.sel = sel[2*k +: 2];
        e.we  = we;
        exp_q.push_back(e);
        if (!we) nr[16*k +: 16] = {ref_mem[e.adr[7:0] + 8'd1], ref_mem[e.adr[7:0]]};
      end
    end
    for (int i = 0; i < 4; i++)
      if (we && sel[i]) ref_mem[base[7:0] + 8'(i)] = dat[8*i +: 8];
    xfer(tag, adr, dat, sel, we, resp, rdat);
    check({tag, ":resp"}, resp, 3'b001);
    check({tag, ":naccess"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tag, ":adr"}, log_q[i].adr, exp_q[i].adr);
      check({tag, ":sel"}, log_q[i].sel, exp_q[i].sel);
      check({tag, ":we"}, log_q[i].we, exp_q[i].we);
      if (we) check({tag, ":wdat"}, log_q[i].dat, exp_q[i].dat);
    end
    if (exp_q.size() == 0) check({tag, ":no_cyc"}, cyc_cycles, 0);
    check({tag, ":rdat"}, rdat, nr);
    exp_rdat = nr;
  endtask

  initial begin
    logic [31:0] rdat;
    logic [2:0]  resp;
    int          seen;
    rst = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'($urandom);
      ref_mem[i] = slv_mem[i];
    end
    exp_rdat = '0;
    repeat (3) tick();
    check("reset:wbs_cyc", wbs_cyc_o, 1'b0);
    check("reset:wbs_stb", wbs_stb_o, 1'b0);
    check("reset:wbs_adr", wbs_adr_o, 32'h0);
    check("reset:resp", {wbm_rty_o, wbm_err_o, wbm_ack_o}, 3'b000);
    check("reset:wbm_dat", wbm_dat_o, 32'h0);
    rst = 1'b0;
    tick();

    run("w_full", 32'h1000, 32'hAABBCCDD, 4'hF, 1'b1, rdat);
    if (log_q.size() == 2) begin
      check("w_full:a0", {log_q[0].adr, 16'h0, log_q[0].dat}, {32'h1000, 16'h0, 16'hCCDD});
      check("w_full:a1", {log_q[1].adr, 16'h0, log_q[1].dat}, {32'h1002, 16'h0, 16'hAABB});
    end

    slv_mem[4] = 8'h34; slv_mem[5] = 8'h12; slv_mem[6] = 8'h78; slv_mem[7] = 8'h56;
    for (int i = 4; i < 8; i++) ref_mem[i] = slv_mem[i];
    run("r_full", 32'h2004, 32'h0, 4'hF, 1'b0, rdat);
    check("r_full:const", rdat, 32'h56781234);

    run("w_hi", 32'h3000, 32'h11223344, 4'hC, 1'b1, rdat);
    if (log_q.size() == 1) check("w_hi:adr_const", log_q[0].adr, 32'h3002);
    run("w_none", 32'h3010, 32'h55667788, 4'h0, 1'b1, rdat);
    run("r_lo", 32'h2006, 32'h0, 4'h3, 1'b0, rdat);

    for (int n = 0; n < 40; n++)
      run("rand", 32'($urandom_range(0, 255)), $urandom, 4'($urandom), 1'($urandom), rdat);

    slv_mode = 1;
    xfer("err", 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, resp, rdat);
    check("err:resp", resp, 3'b010);
    check("err:naccess", log_q.size(), 1);
    slv_mode = 3;
    xfer("rty", 32'h48, 32'hDEADBEEF, 4'hF, 1'b1, resp, rdat);
    check("rty:resp", resp, 3'b100);
    check("rty:naccess", log_q.size(), 1);

    // Master abandons the cycle while the slave stalls.
    slv_mode = 2;
    start(32'h50, 32'h0BADF00D, 4'hF, 1'b1);
    repeat (5) tick();
    check("drop:stb_before", {wbs_cyc_o, wbs_stb_o}, 2'b11);
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    tick();
    check("drop:stb_after", {wbs_cyc_o, wbs_stb_o}, 2'b00);
    seen = 0;
    repeat (4) begin
      tick();
      if ({wbm_rty_o, wbm_err_o, wbm_ack_o} != 3'b000) seen++;
    end
    check("drop:no_resp", seen, 0);

`ifdef WB_DOWNSIZER_TIMEOUT_EN
    xfer("tmo", 32'h60, 32'h12345678, 4'hF, 1'b1, resp, rdat);
    check("tmo:resp", resp, 3'b010);
    check("tmo:access_cycles", stb_cycles, 8);
`else
    start(32'h60, 32'h12345678, 4'hF, 1'b1);
    seen = 0;
    repeat (40) begin
      tick();
      if ({wbm_rty_o, wbm_err_o, wbm_ack_o} != 3'b000) seen++;
    end
    check("wait:no_resp", seen, 0);
    check("wait:stb_held", wbs_stb_o, 1'b1);
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    repeat (2) tick();
`endif

    // Reset in the middle of a stalled access.
    start(32'h70, 32'hCAFEF00D, 4'hF, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_mid:wbs", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o}, 5'b0);
    check("rst_mid:wbs_adr_dat", {wbs_adr_o, wbs_dat_o}, 48'h0);
    check("rst_mid:wbm", {wbm_rty_o, wbm_err_o, wbm_ack_o}, 3'b000);
    check("rst_mid:wbm_dat", wbm_dat_o, 32'h0);
    rst = 1'b0;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    slv_mode = 0;
    exp_rdat = '0;
    tick();
    run("post_rst", 32'h2004, 32'h0, 4'hF, 1'b0, rdat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
